// File: rtl/led_frame_scheduler.sv
// Double-buffered 8x8 red/green frame store with row-scan prescaler; swaps only on frame_done.
// Optional LED_FRAME_CNT_EN adds a 16-bit frame_count output.
module led_frame_scheduler #(
  parameter int TICK_DIV = 1000,
  parameter int CNT_W    = 10
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 wr_en,
  input  logic [2:0]           wr_row,
  input  logic [2:0]           wr_col,
  input  logic [1:0]           wr_color,
  input  logic                 clear_req,
  input  logic                 swap_req,
  output logic                 busy,
  output logic                 swap_ack,
  output logic                 scan_tick,
  output logic [2:0]           scan_row,
  output logic                 frame_done,
`ifdef LED_FRAME_CNT_EN
  output logic [15:0]          frame_count,
`endif
  output logic [7:0][7:0]      red_array,
  output logic [7:0][7:0]      green_array
);

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_CLEAR     = 2'd1,
    ST_SWAP_WAIT = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(TICK_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  logic [CNT_W-1:0]       presc_q;
  logic [2:0]             row_q;
  state_t                 state_q;
  logic [2:0]             clr_row_q;
  logic                   pend_q;
  logic                   pend_d;
  logic                   front_q;
  logic                   back_sel;
  logic                   swap_ack_q;
  logic [1:0][7:0][7:0]   red_q;
  logic [1:0][7:0][7:0]   green_q;

  assign scan_tick  = (presc_q == TICK_LAST);
  assign frame_done = scan_tick && (row_q == 3'd7);
  assign scan_row   = row_q;
  assign busy       = (state_q != ST_IDLE);
  assign swap_ack   = swap_ack_q;
  assign back_sel   = ~front_q;
  assign pend_d     = pend_q | swap_req;

  assign red_array   = red_q[front_q];
  assign green_array = green_q[front_q];

  // Row-scan timebase runs regardless of FSM state.
  always_ff @(posedge clock) begin
    if (reset) begin
      presc_q <= '0;
      row_q   <= 3'd0;
    end else if (scan_tick) begin
      presc_q <= '0;
      row_q   <= row_q + 3'd1;
    end else begin
      presc_q <= presc_q + CNT_ONE;
    end
  end

  // Writes and clears only ever touch the back buffer; front changes only by the swap.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      clr_row_q  <= 3'd0;
      pend_q     <= 1'b0;
      front_q    <= 1'b0;
      swap_ack_q <= 1'b0;
      red_q      <= '0;
      green_q    <= '0;
    end else begin
      swap_ack_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (wr_en) begin
            red_q[back_sel][wr_row][wr_col]   <= wr_color[0];
            green_q[back_sel][wr_row][wr_col] <= wr_color[1];
          end
          if (clear_req) begin
            state_q   <= ST_CLEAR;
            clr_row_q <= 3'd0;
            pend_q    <= swap_req;
          end else if (swap_req) begin
            state_q <= ST_SWAP_WAIT;
          end
        end
        ST_CLEAR: begin
          red_q[back_sel][clr_row_q]   <= 8'h00;
          green_q[back_sel][clr_row_q] <= 8'h00;
          if (clr_row_q == 3'd7) begin
            pend_q  <= 1'b0;
            state_q <= pend_d ? ST_SWAP_WAIT : ST_IDLE;
          end else begin
            clr_row_q <= clr_row_q + 3'd1;
            pend_q    <= pend_d;
          end
        end
        ST_SWAP_WAIT: begin
          if (frame_done) begin
            front_q    <= ~front_q;
            swap_ack_q <= 1'b1;
            state_q    <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

`ifdef LED_FRAME_CNT_EN
  logic [15:0] frame_cnt_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      frame_cnt_q <= 16'd0;
    end else if (frame_done) begin
      frame_cnt_q <= frame_cnt_q + 16'd1;
    end
  end

  assign frame_count = frame_cnt_q;
`endif

endmodule

// File: tb/tb_led_frame_scheduler.sv
// Scoreboard bench for led_frame_scheduler (TICK_DIV=4): expected outputs queued per driven cycle.
module tb_led_frame_scheduler;

  localparam int TD = 4;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic             reset, wr_en, clear_req, swap_req;
  logic [2:0]       wr_row, wr_col;
  logic [1:0]       wr_color;
  logic             busy, swap_ack, scan_tick, frame_done;
  logic [2:0]       scan_row;
  logic [7:0][7:0]  red_array, green_array;
`ifdef LED_FRAME_CNT_EN
  logic [15:0]      frame_count;
`endif

  led_frame_scheduler #(.TICK_DIV(TD), .CNT_W(2)) dut (
    .clock       (clock),
    .reset       (reset),
    .wr_en       (wr_en),
    .wr_row      (wr_row),
    .wr_col      (wr_col),
    .wr_color    (wr_color),
    .clear_req   (clear_req),
    .swap_req    (swap_req),
    .busy        (busy),
    .swap_ack    (swap_ack),
    .scan_tick   (scan_tick),
    .scan_row    (scan_row),
    .frame_done  (frame_done),
`ifdef LED_FRAME_CNT_EN
    .frame_count (frame_count),
`endif
    .red_array   (red_array),
    .green_array (green_array)
  );

  typedef struct packed {
    logic [6:0]  ctrl;
    logic [63:0] red;
    logic [63:0] green;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_ack, n_tick, n_fd;

  // Reference model state
  int       m_k, m_st, m_cr;
  bit       m_pend, m_front, m_ack;
  bit [1:0] m_img [2][8][8];

  task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h expected=%h t=%0t", tag, act, exp, $time);
    end
  endtask

  function automatic exp_t model_outputs();
    exp_t e;
    bit tick, fd;
    int row, f;
    logic [7:0][7:0] rp, gp;
    tick = (m_k % TD) == TD - 1;
    row  = (m_k / TD) % 8;
    fd   = tick && (row == 7);
    f    = m_front ? 1 : 0;
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++) begin
        rp[r][c] = m_img[f][r][c][0];
        gp[r][c] = m_img[f][r][c][1];
      end
    e.ctrl  = {(m_st != 0), m_ack, tick, fd, 3'(row)};
    e.red   = rp;
    e.green = gp;
    return e;
  endfunction

  task automatic model_step(input bit rst, input bit we, input logic [2:0] r, input logic [2:0] c,
                            input logic [1:0] col, input bit clr, input bit sw);
    bit tick, fd;
    int bk;
    tick = (m_k % TD) == TD - 1;
    fd   = tick && ((m_k / TD) % 8 == 7);
    bk   = m_front ? 0 : 1;
    if (rst) begin
      m_k = 0; m_st = 0; m_cr = 0; m_pend = 0; m_front = 0; m_ack = 0;
      foreach (m_img[b, i, j]) m_img[b][i][j] = 2'b00;
    end else begin
      m_k   = (m_k + 1) % (TD * 8);
      m_ack = 0;
      case (m_st)
        0: begin
          if (we) m_img[bk][r][c] = col;
          if (clr) begin m_st = 1; m_cr = 0; m_pend = sw; end
          else if (sw) m_st = 2;
        end
        1: begin
          for (int j = 0; j < 8; j++) m_img[bk][m_cr][j] = 2'b00;
          if (sw) m_pend = 1;
          if (m_cr == 7) begin m_st = m_pend ? 2 : 0; m_pend = 0; end
          else m_cr++;
        end
        default: begin
          if (fd) begin m_front = !m_front; m_ack = 1; m_st = 0; end
        end
      endcase
    end
  endtask

  task automatic cycle(input bit rst, input bit we, input logic [2:0] r, input logic [2:0] c,
                       input logic [1:0] col, input bit clr, input bit sw);
    exp_t e;
    reset = rst; wr_en = we; wr_row = r; wr_col = c; wr_color = col;
    clear_req = clr; swap_req = sw;
    model_step(rst, we, r, c, col, clr, sw);
    q.push_back(model_outputs());
    @(posedge clock);
    #1;
    e = q.pop_front();
    check_val("ctrl", {57'd0, busy, swap_ack, scan_tick, frame_done, scan_row}, {57'd0, e.ctrl});
    check_val("red", red_array, e.red);
    check_val("green", green_array, e.green);
    n_ack  += int'(swap_ack);
    n_tick += int'(scan_tick);
    n_fd   += int'(frame_done);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, 0, 3'd0, 3'd0, 2'd0, 0, 0);
  endtask

  task automatic wr(input logic [2:0] r, input logic [2:0] c, input logic [1:0] col);
    cycle(0, 1, r, c, col, 0, 0);
  endtask

  task automatic wait_ack(input int target, input int max_cyc);
    int i;
    i = 0;
    while (n_ack < target && i < max_cyc) begin
      idle(1);
      i++;
    end
    check_val("ack_wait", 64'(n_ack >= target), 64'd1);
  endtask

  task automatic wait_fd(input int max_cyc);
    int i;
    i = 0;
    while (frame_done !== 1'b1 && i < max_cyc) begin
      idle(1);
      i++;
    end
    check_val("fd_wait", 64'(frame_done), 64'd1);
  endtask

  initial begin
    reset = 1'b1; wr_en = 1'b0; wr_row = '0; wr_col = '0; wr_color = '0;
    clear_req = 1'b0; swap_req = 1'b0;

    cycle(1, 0, 3'd0, 3'd0, 2'd0, 0, 0);
    cycle(1, 0, 3'd0, 3'd0, 2'd0, 0, 0);
    check_val("rst_busy", 64'(busy), 64'd0);
    check_val("rst_row", 64'(scan_row), 64'd0);

    // Scan timebase: 8 ticks and one frame_done per 32 cycles
    n_tick = 0; n_fd = 0; n_ack = 0;
    idle(32);
    check_val("tick_cnt", 64'(n_tick), 64'd8);
    check_val("fd_cnt", 64'(n_fd), 64'd1);

    // Write then swap; pixel appears only with swap_ack
    wr(3'd3, 3'd5, 2'b11);
    check_val("wr_no_disp", 64'(red_array[3][5]), 64'd0);
    cycle(0, 0, 3'd0, 3'd0, 2'd0, 0, 1);
    check_val("swap_busy", 64'(busy), 64'd1);
    n_ack = 0;
    wait_ack(1, 40);
    check_val("swap_red35", 64'(red_array[3][5]), 64'd1);
    check_val("swap_grn35", 64'(green_array[3][5]), 64'd1);
    idle(1);
    check_val("post_swap_busy", 64'(busy), 64'd0);

    // Write during CLEAR is dropped
    wr(3'd2, 3'd2, 2'b11);
    cycle(0, 0, 3'd0, 3'd0, 2'd0, 1, 0);
    cycle(0, 1, 3'd2, 3'd2, 2'b11, 0, 0);
    idle(8);
    cycle(0, 0, 3'd0, 3'd0, 2'd0, 0, 1);
    n_ack = 0;
    wait_ack(1, 40);
    check_val("drop_wr_red", 64'(red_array[2][2]), 64'd0);
    check_val("drop_wr_grn", 64'(green_array[2][2]), 64'd0);

    // clear_req + swap_req together: clear first, then a single swap of an empty frame
    wr(3'd1, 3'd1, 2'b01);
    cycle(0, 0, 3'd0, 3'd0, 2'd0, 1, 1);
    n_ack = 0;
    idle(8);
    check_val("clrswap_busy", 64'(busy), 64'd1);
    wait_ack(1, 40);
    check_val("clrswap_red", red_array, 64'd0);
    check_val("clrswap_grn", green_array, 64'd0);
    idle(40);
    check_val("clrswap_acks", 64'(n_ack), 64'd1);

    // Repeated swap_req during SWAP_WAIT yields one swap
    wr(3'd6, 3'd6, 2'b10);
    wait_fd(40);
    cycle(0, 0, 3'd0, 3'd0, 2'd0, 0, 1);
    n_ack = 0;
    for (int i = 0; i < 3; i++) begin
      idle(1);
      cycle(0, 0, 3'd0, 3'd0, 2'd0, 0, 1);
    end
    wait_ack(1, 40);
    idle(40);
    check_val("rep_acks", 64'(n_ack), 64'd1);
    check_val("rep_grn66", 64'(green_array[6][6]), 64'd1);

    // Random pixel pattern then swap
    for (int i = 0; i < 6; i++)
      wr(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)));
    cycle(0, 0, 3'd0, 3'd0, 2'd0, 0, 1);
    n_ack = 0;
    wait_ack(1, 40);

    // Reset during SWAP_WAIT aborts the swap
    wr(3'd4, 3'd4, 2'b11);
    cycle(0, 0, 3'd0, 3'd0, 2'd0, 0, 1);
    idle(3);
    cycle(1, 0, 3'd0, 3'd0, 2'd0, 0, 0);
    check_val("rst_sw_busy", 64'(busy), 64'd0);
    check_val("rst_sw_row", 64'(scan_row), 64'd0);
    check_val("rst_sw_red", red_array, 64'd0);
    n_ack = 0;
    idle(40);
    check_val("rst_sw_acks", 64'(n_ack), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/led_frame_scheduler.md
Name: led_frame_scheduler

Overview:
Double-buffered frame store and scan sequencer for the 8x8 red/green LED matrix driver. Game logic writes pixels into a hidden back buffer. The block presents the front buffer as red_array/green_array to the matrix driver. It issues a row-advance tick and swaps buffers only at a frame boundary, so a partially drawn frame is never displayed.

Parameters:
TICK_DIV, 1000, clock cycles per row-scan tick (must be >= 2)
CNT_W, 10, width of prescaler counter (must satisfy 2**CNT_W >= TICK_DIV)

Ports:
clock  input  1  system clock
reset  input  1  synchronous, active-high reset
wr_en  input  1  pixel write strobe, accepted only when busy=0
wr_row  input  3  pixel row index
wr_col  input  3  pixel column index
wr_color  input  2  bit0 = red, bit1 = green; 00 off, 11 both
clear_req  input  1  one-cycle pulse: clear back buffer
swap_req  input  1  one-cycle pulse: request front/back swap
busy  output  1  high in CLEAR or SWAP_WAIT
swap_ack  output  1  one-cycle pulse when swap performed
scan_tick  output  1  one-cycle row-advance pulse
scan_row  output  3  current scanned row
frame_done  output  1  one-cycle pulse on row 7 -> 0 wrap
red_array  output  8x8  front buffer red plane, [row][col]
green_array  output  8x8  front buffer green plane, [row][col]

Behaviour:
- Reset: both buffers all-zero; front select = 0; prescaler = 0; scan_row = 0; state IDLE. All outputs 0; pending flags cleared. Reset mid-clear or mid-swap-wait aborts the operation with no swap_ack.
- Prescaler: counts 0..TICK_DIV-1 and wraps. scan_tick = 1 in the cycle the count equals TICK_DIV-1. scan_row increments on scan_tick and wraps 7 -> 0. frame_done = scan_tick and scan_row == 7.
- Writes: in IDLE with wr_en=1, back[wr_row][wr_col] takes wr_color at the next edge. Writes while busy=1 are dropped silently. red_array/green_array never change due to a write.
- FSM states: IDLE, CLEAR, SWAP_WAIT.
- IDLE -> CLEAR on clear_req. CLEAR zeroes one back-buffer row per cycle, rows 0..7 (8 cycles), then returns to IDLE, or goes to SWAP_WAIT if a swap is pending.
- IDLE -> SWAP_WAIT on swap_req.
- swap_req arriving during CLEAR is latched as pending.
- clear_req and swap_req in the same IDLE cycle: clear runs first, then swap.
- SWAP_WAIT: on the cycle frame_done=1, toggle front select and pulse swap_ack in the following cycle, then go to IDLE. The new front appears on red_array/green_array from that same edge.
- Back-buffer content after a swap is the previous front frame (no auto-copy).
- Repeated swap_req while already in SWAP_WAIT or pending: ignored, giving one swap only.
- clear_req in SWAP_WAIT: ignored.
- Ticking and scan_row advance continue in every state.

Optional Feature:
LED_FRAME_CNT_EN:
- When defined: adds output frame_count[15:0]. Resets to 0, increments on every frame_done, wraps at 16'hFFFF -> 0.
- When undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset, TICK_DIV=4 -> scan_tick every 4th cycle; scan_row 0,1,...,7,0; frame_done once per 32 cycles; arrays all 0.
- Write (3,5,2'b11) in IDLE, then swap_req -> busy=1 until next frame_done; red_array[3][5] = green_array[3][5] = 1 only after the swap_ack cycle.
- Write issued while busy=1 (during CLEAR) -> dropped; back buffer at that pixel remains 0 after the next swap.
- clear_req and swap_req in the same cycle -> 8 CLEAR cycles, then SWAP_WAIT, exactly one swap_ack, displayed frame all 0.
- swap_req pulsed 3 times during SWAP_WAIT -> a single swap_ack; front select toggles once.
- Assert reset in SWAP_WAIT -> no swap_ack, busy=0, arrays 0, scan_row 0 on the next cycle.
